// File: rtl/alu_req_arbiter.sv
// Round-robin front end that shares one registered-latency ALU between two requesters.
// Optional ALU_ARB_PERF_EN adds saturating grant/error counters as extra output ports.
module alu_req_arbiter #(
  parameter int DATA_W  = 4,
  parameter int RES_W   = 10,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_opcode,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_opcode,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [RES_W-1:0]  alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [RES_W-1:0]  rsp_data,
  output logic              rsp_err
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [15:0]       perf_gnt0,
  output logic [15:0]       perf_gnt1,
  output logic [7:0]        perf_err
`endif
);

  localparam int CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                rr_q, rr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          alu_opcode_q, alu_opcode_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_id_q, rsp_id_d;
  logic [RES_W-1:0]    rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  logic                any_valid;
  logic                idle_ok;
  logic                accept;
  logic                gnt_id;
  logic [3:0]          gnt_op;
  logic [DATA_W-1:0]   gnt_a;
  logic [DATA_W-1:0]   gnt_b;
  logic                gnt_legal;

  // On contention the requester that did not win last time is granted.
  assign any_valid  = req0_valid | req1_valid;
  assign gnt_id     = (req0_valid && req1_valid) ? ~rr_q : ~req0_valid;
  assign idle_ok    = (state_q == S_IDLE) && rst_n;
  assign accept     = idle_ok && any_valid;
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept && gnt_id;
  assign gnt_op     = gnt_id ? req1_opcode : req0_opcode;
  assign gnt_a      = gnt_id ? req1_a : req0_a;
  assign gnt_b      = gnt_id ? req1_b : req0_b;
  assign gnt_legal  = (gnt_op >= 4'b0101) && (gnt_op <= 4'b1011);

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rr_d     = gnt_id;
          rsp_id_d = gnt_id;
          if (gnt_legal) begin
            alu_opcode_d = gnt_op;
            alu_a_d      = gnt_a;
            alu_b_d      = gnt_b;
            cnt_d        = CNT_W'(ALU_LAT);
            state_d      = S_WAIT;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            state_d     = S_RESP;
          end
        end
      end
      S_WAIT: begin
        // ALU_LAT edges for the ALU output register to settle, capture on the next one.
        if (cnt_q == '0) begin
          rsp_data_d   = alu_out;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          alu_opcode_d = 4'b0000;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_q         <= 1'b1;
      cnt_q        <= '0;
      alu_opcode_q <= 4'b0000;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;

`ifdef ALU_ARB_PERF_EN
  logic [15:0] perf_gnt0_q, perf_gnt0_d;
  logic [15:0] perf_gnt1_q, perf_gnt1_d;
  logic [7:0]  perf_err_q, perf_err_d;

  always_comb begin
    perf_gnt0_d = perf_gnt0_q;
    perf_gnt1_d = perf_gnt1_q;
    perf_err_d  = perf_err_q;
    if (req0_ready && !(&perf_gnt0_q)) perf_gnt0_d = perf_gnt0_q + 16'd1;
    if (req1_ready && !(&perf_gnt1_q)) perf_gnt1_d = perf_gnt1_q + 16'd1;
    if (accept && !gnt_legal && !(&perf_err_q)) perf_err_d = perf_err_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_gnt0_q <= '0;
      perf_gnt1_q <= '0;
      perf_err_q  <= '0;
    end else begin
      perf_gnt0_q <= perf_gnt0_d;
      perf_gnt1_q <= perf_gnt1_d;
      perf_err_q  <= perf_err_d;
    end
  end

  assign perf_gnt0 = perf_gnt0_q;
  assign perf_gnt1 = perf_gnt1_q;
  assign perf_err  = perf_err_q;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a one-cycle registered ALU model.
module tb_alu_req_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_opcode, req0_a, req0_b, req1_opcode, req1_a, req1_b;
  logic [3:0] alu_opcode, alu_a, alu_b;
  logic [9:0] alu_out;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [9:0] rsp_data;
`ifdef ALU_ARB_PERF_EN
  logic [15:0] perf_gnt0, perf_gnt1;
  logic [7:0]  perf_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_req_arbiter #(.DATA_W(4), .RES_W(10), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
`ifdef ALU_ARB_PERF_EN
    , .perf_gnt0(perf_gnt0), .perf_gnt1(perf_gnt1), .perf_err(perf_err)
`endif
  );

  // ALU model: result registered one edge after its inputs; no-op holds the output.
  always @(posedge clk) begin
    case (alu_opcode)
      4'b0101: alu_out <= {6'b0, alu_a} + {6'b0, alu_b};
      4'b0110: alu_out <= {6'b0, alu_a & alu_b};
      4'b0111: alu_out <= {6'b0, alu_a | alu_b};
      4'b1000: alu_out <= {6'b0, alu_a ^ alu_b};
      4'b1001: alu_out <= {6'b0, alu_a} - {6'b0, alu_b};
      4'b1010: alu_out <= {6'b0, alu_a} * {6'b0, alu_b};
      4'b1011: alu_out <= {2'b0, alu_a, alu_b};
      default: alu_out <= alu_out;
    endcase
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_opcode = 4'b0110; req0_a = 4'hC; req0_b = 4'hA;
    req1_valid = 1'b1; req1_opcode = 4'b0111; req1_a = 4'h1; req1_b = 4'h2;
    repeat (2) step();
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0 got %b exp 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1 got %b exp 0", req1_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (alu_opcode !== 4'b0000) begin errors++; $display("FAIL reset_alu_opcode got %b exp 0000", alu_opcode); end
    checks++; if (rsp_data !== 10'h000) begin errors++; $display("FAIL reset_rsp_data got %h exp 000", rsp_data); end
`ifdef ALU_ARB_PERF_EN
    checks++; if (perf_gnt0 !== 16'd0) begin errors++; $display("FAIL reset_perf_gnt0 got %0d exp 0", perf_gnt0); end
`endif
    $display("reset: readys=%b%b rsp_valid=%b alu_opcode=%b", req1_ready, req0_ready, rsp_valid, alu_opcode);
  endtask

  task automatic test_single_op;
    rst_n = 1'b1; req1_valid = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready0 got %b exp 1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready1 got %b exp 0", req1_ready); end
    step(); // E0
    req0_valid = 1'b0;
    checks++; if (alu_opcode !== 4'b0110) begin errors++; $display("FAIL single_alu_opcode got %b exp 0110", alu_opcode); end
    checks++; if (alu_a !== 4'hC || alu_b !== 4'hA) begin errors++; $display("FAIL single_alu_ab got %h/%h exp C/A", alu_a, alu_b); end
    step(); // E0+1
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_early got %b exp 0", rsp_valid); end
    step(); // E0+2
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %b exp 1", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_rsp_id got %b exp 0", rsp_id); end
    checks++; if (rsp_data !== 10'h008) begin errors++; $display("FAIL single_rsp_data got %h exp 008", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL single_rsp_err got %b exp 0", rsp_err); end
    checks++; if (alu_opcode !== 4'b0000) begin errors++; $display("FAIL single_alu_noop got %b exp 0000", alu_opcode); end
    $display("single: id=%0d data=%h err=%b", rsp_id, rsp_data, rsp_err);
    rsp_ready = 1'b1;
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_done got %b exp 0", rsp_valid); end
  endtask

  task automatic test_contention;
    int g_id[8];
    int g_cyc[8];
    int gcnt;
    int rcnt;
    logic [9:0] exp_data;
    gcnt = 0; rcnt = 0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_opcode = 4'b0101; req0_a = 4'h3; req0_b = 4'h4;
    req1_valid = 1'b1; req1_opcode = 4'b1000; req1_a = 4'hF; req1_b = 4'h3;
    #1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (req0_ready && req1_ready) begin
        checks++; errors++; $display("FAIL cont_both_ready got 11 exp one-hot at cycle %0d", cyc);
      end
      if ((req0_ready || req1_ready) && gcnt < 8) begin
        g_id[gcnt] = req1_ready ? 1 : 0; g_cyc[gcnt] = cyc; gcnt++;
      end
      if (rsp_valid) begin
        exp_data = (rcnt % 2 == 1) ? 10'h00C : 10'h007;
        checks++; if (rsp_id !== 1'((rcnt % 2))) begin errors++; $display("FAIL cont_rsp_id got %b exp %0d", rsp_id, rcnt % 2); end
        checks++; if (rsp_data !== exp_data || rsp_err !== 1'b0) begin errors++; $display("FAIL cont_rsp_data got %h err %b exp %h err 0", rsp_data, rsp_err, exp_data); end
        $display("contention: rsp id=%0d data=%h", rsp_id, rsp_data);
        rcnt++;
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if (gcnt !== 4) begin errors++; $display("FAIL cont_grant_count got %0d exp 4", gcnt); end
    checks++; if (rcnt !== 4) begin errors++; $display("FAIL cont_rsp_count got %0d exp 4", rcnt); end
    for (int i = 0; i < 4; i++) begin
      if (i < gcnt) begin
        checks++; if (g_id[i] !== (i % 2)) begin errors++; $display("FAIL cont_grant_id[%0d] got %0d exp %0d", i, g_id[i], i % 2); end
        checks++; if (g_cyc[i] !== 4 * i) begin errors++; $display("FAIL cont_grant_cycle[%0d] got %0d exp %0d", i, g_cyc[i], 4 * i); end
      end
    end
    step();
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_opcode = 4'b1010; req0_a = 4'h7; req0_b = 4'h6;
    req1_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL bp_grant got %b%b exp 01", req1_ready, req0_ready); end
    step(); // E0
    req0_valid = 1'b0;
    step();
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 10'h02A) begin errors++; $display("FAIL bp_first got v=%b d=%h exp v=1 d=02A", rsp_valid, rsp_data); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 10'h02A || rsp_err !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b id=%b d=%h e=%b exp v=1 id=0 d=02A e=0", i, rsp_valid, rsp_id, rsp_data, rsp_err);
      end
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b%b exp 00", i, req1_ready, req0_ready); end
    end
    $display("backpressure: id=%0d data=%h held", rsp_id, rsp_data);
    rsp_ready = 1'b1;
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", rsp_valid); end
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_ready1 got %b exp 1", req1_ready); end
    req1_valid = 1'b0;
  endtask

  task automatic test_illegal;
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_opcode = 4'b1111; req1_a = 4'h3; req1_b = 4'h3;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL ill_ready1 got %b exp 1", req1_ready); end
    step(); // E0
    req1_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1) begin errors++; $display("FAIL ill_rsp got v=%b id=%b exp v=1 id=1", rsp_valid, rsp_id); end
    checks++; if (rsp_err !== 1'b1 || rsp_data !== 10'h000) begin errors++; $display("FAIL ill_err got e=%b d=%h exp e=1 d=000", rsp_err, rsp_data); end
    checks++; if (alu_opcode !== 4'b0000) begin errors++; $display("FAIL ill_alu_opcode got %b exp 0000", alu_opcode); end
    checks++; if (alu_a !== 4'h7 || alu_b !== 4'h6) begin errors++; $display("FAIL ill_alu_ab got %h/%h exp 7/6", alu_a, alu_b); end
    $display("illegal: id=%0d err=%b data=%h", rsp_id, rsp_err, rsp_data);
    rsp_ready = 1'b1;
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ill_done got %b exp 0", rsp_valid); end
`ifdef ALU_ARB_PERF_EN
    checks++; if (perf_err !== 8'd1) begin errors++; $display("FAIL ill_perf_err got %0d exp 1", perf_err); end
`endif
  endtask

  task automatic test_midop_reset;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_opcode = 4'b0101; req0_a = 4'h1; req0_b = 4'h1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL mid_ready0 got %b exp 1", req0_ready); end
    step(); // E0, now in WAIT
    req0_valid = 1'b0;
    checks++; if (alu_opcode !== 4'b0101) begin errors++; $display("FAIL mid_alu_opcode got %b exp 0101", alu_opcode); end
    rst_n = 1'b0;
    step();
    checks++; if (rsp_valid !== 1'b0 || alu_opcode !== 4'b0000) begin errors++; $display("FAIL mid_in_reset got v=%b op=%b exp v=0 op=0000", rsp_valid, alu_opcode); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_rsp[%0d] got %b exp 0", i, rsp_valid); end
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL mid_rr_after_reset got %b%b exp 01", req1_ready, req0_ready); end
`ifdef ALU_ARB_PERF_EN
    checks++; if (perf_gnt0 !== 16'd0 || perf_gnt1 !== 16'd0 || perf_err !== 8'd0) begin
      errors++; $display("FAIL mid_perf got %0d/%0d/%0d exp 0/0/0", perf_gnt0, perf_gnt1, perf_err);
    end
`endif
    $display("midop_reset: rsp_valid=%b winner=req%0d", rsp_valid, req1_ready ? 1 : 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  initial begin
    alu_out = 10'h000;
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_illegal();
    test_midop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
